// File: rtl/display_scan_ctrl_pkg.sv
// Shared display definitions: digit count, one-hot digit decode and anode polarity helpers.
package display_scan_ctrl_pkg;

    localparam int DISPLAY_NUM_DIGITS = 6;
    localparam int MAX_DIGITS         = 16;

    function automatic logic [MAX_DIGITS-1:0] onehot_decode(input logic [31:0] sel,
                                                            input int unsigned num_digits);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < num_digits && sel == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] anode_polarity(input logic [MAX_DIGITS-1:0] vec,
                                                             input bit active_low);
        return active_low ? ~vec : vec;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_pwm_dimmer.sv
// Free-running brightness PWM: on while the counter is below the requested duty.
module pwm_dimmer #(
    parameter int PWM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] brightness,
    output logic             pwm_on
);

    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_W'(1);
    end

    // Full-scale brightness bypasses the compare so it really is 100% duty.
    assign pwm_on = (brightness == '1) || (pwm_cnt < brightness);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment digit scanner with anode dead-time, blink masking,
// PWM dimming and a frame-start strobe.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS       = DISPLAY_NUM_DIGITS,
    parameter int SEL_W            = 3,
    parameter int PWM_W            = 4,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  blink_tick,
    input  logic [NUM_DIGITS-1:0] blink_en,
    input  logic [PWM_W-1:0]      brightness,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  frame_start
);

    localparam logic [SEL_W:0]      LAST_SEL  = (SEL_W+1)'(NUM_DIGITS-1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? '1 : '0;

    logic                  pwm_on;
    logic                  blink_phase;
    logic                  sel_bad;
    logic                  dead_time;
    logic                  blink_hit;
    logic                  lit;
    logic                  frame_nxt;
    logic [SEL_W-1:0]      sel_nxt;
    logic [MAX_DIGITS-1:0] sel_onehot;
    logic [MAX_DIGITS-1:0] anode_full;
    logic [NUM_DIGITS-1:0] anode_nxt;
    logic                  pol_unused;

    pwm_dimmer #(.PWM_W(PWM_W)) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .brightness (brightness),
        .pwm_on     (pwm_on)
    );

    always_comb begin
        sel_nxt   = sel;
        frame_nxt = 1'b0;
        sel_bad   = {1'b0, sel} > LAST_SEL;
        if (sel_bad) begin
            sel_nxt = '0;
        end else if (tick && enable) begin
            if ({1'b0, sel} == LAST_SEL) begin
                sel_nxt   = '0;
                frame_nxt = 1'b1;
            end else begin
                sel_nxt = sel + SEL_W'(1);
            end
        end

        // Any select change blanks the anodes for one clk so the segment mux settles.
        dead_time  = (sel_nxt != sel);
        sel_onehot = onehot_decode(32'(sel), NUM_DIGITS);
        blink_hit  = blink_phase && |(sel_onehot & MAX_DIGITS'(blink_en));
        lit        = enable && pwm_on && !blink_hit && !dead_time;
        anode_full = anode_polarity(lit ? sel_onehot : '0, ANODE_ACTIVE_LOW);
        anode_nxt  = anode_full[NUM_DIGITS-1:0];
    end

    assign pol_unused = ^anode_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= '0;
            anode       <= ANODE_OFF;
            frame_start <= 1'b0;
            blink_phase <= 1'b0;
        end else begin
            sel         <= sel_nxt;
            anode       <= anode_nxt;
            frame_start <= frame_nxt;
            blink_phase <= blink_phase ^ blink_tick;
        end
    end

endmodule
